dllp_tx_arbiter: RTL and testbench
==================================

# dllp_tx_arbiter

Packet-level arbiter that owns the single data link layer transmit AXI-Stream toward the physical layer. It shares that stream between three requesters: the replay stream from the retry manager, locally generated DLLPs (Ack/Nak/UpdateFC), and new sequenced TLPs. Each grant is held for a whole packet. The block registers the output and includes an optional starvation guard for new TLPs.

## Interface
Parameters:
- DATA_WIDTH, 32, AXIS data width for all ports
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 1, tuser width, passed through unchanged
- STARVE_LIMIT, 4, consecutive non-TLP grants tolerated while a TLP waits; range 1..15

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- s_rpl_axis_{tdata,tkeep,tvalid,tlast,tuser}  in  DATA/KEEP/1/1/USER  replay stream from the retry manager
- s_rpl_axis_tready  out  1
- s_dllp_axis_{tdata,tkeep,tvalid,tlast,tuser}  in  as above  DLLP stream
- s_dllp_axis_tready  out  1
- s_tlp_axis_{tdata,tkeep,tvalid,tlast,tuser}  in  as above  new TLP stream
- s_tlp_axis_tready  out  1
- m_axis_{tdata,tkeep,tvalid,tlast,tuser}  out  DATA/KEEP/1/1/USER  link stream
- m_axis_tready  in  1
- grant_o  out  3  one-hot active source: bit0 replay, bit1 dllp, bit2 tlp; 0 when idle
- tlp_blocked_o  out  1  high while s_tlp_axis_tvalid is high and the TLP port is not granted

## Operation
- States: ST_ARB_IDLE, ST_ARB_RPL, ST_ARB_DLLP, ST_ARB_TLP.
- ST_ARB_IDLE:
  - Samples the three tvalid inputs.
  - Fixed priority: replay > DLLP > TLP.
  - Moves to the winner's state on the next edge. With no tvalid, stays idle.
- ST_ARB_x (packet lock):
  - Only the granted port's tready may be high: s_x_tready = !m_axis_tvalid | m_axis_tready.
  - An accepted beat (s_x_tvalid & s_x_tready) is loaded into the output register.
  - When the accepted beat has tlast=1, the next state is ST_ARB_IDLE.
- Output register:
  - Loaded only on an accepted input beat.
  - Holds its value while m_axis_tvalid & !m_axis_tready.
  - m_axis_tvalid clears when the register is drained and no beat is loaded in that cycle.
- A replay request that arrives during a TLP packet waits for that TLP's tlast. No preemption occurs at any time.
- An input tvalid that drops mid-packet does not release the lock. The arbiter waits for the granted port's tlast.
- grant_o is a decode of the state. tlp_blocked_o is combinational from the state and s_tlp_axis_tvalid.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0, all s_*_tready=0, grant_o=0, tlp_blocked_o=0, state=ST_ARB_IDLE, starvation counter=0.
- Latency: an input beat accepted at edge N is on m_axis at N+1.
- Arbitration costs one idle cycle between packets. Back-to-back packets therefore have exactly one bubble cycle on the input side. The output side shows no bubble if m_axis_tready was low.
- Throughput within a packet is one beat per cycle when m_axis_tready is held high.
- Reset asserted mid-packet: the output clears immediately, the partial packet is dropped, and arbitration restarts from idle after release. Senders are responsible for re-sending.
- A single-beat packet (tvalid & tlast on the first beat) returns the arbiter to idle on the cycle after acceptance.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments at each IDLE grant to replay or DLLP while s_tlp_axis_tvalid=1.
  - The counter clears on a TLP grant, or when s_tlp_axis_tvalid=0 at arbitration.
  - When counter ≥ STARVE_LIMIT, the TLP port wins the next arbitration regardless of priority.
- Macro undefined: strict fixed priority; no counter is present in the RTL.

## Structure
- pcie_datalink_pkg holds:
  - the state typedef arb_st_e;
  - the grant bit index constants ARB_RPL_IDX=0, ARB_DLLP_IDX=1, ARB_TLP_IDX=2.
- One sub-module, axis_out_reg: the single-entry output register with the tready-propagation rule. It is reusable by other link-side blocks.
- Source muxing and the FSM stay in the top module.

## Test plan
- Reset mid-packet:
  - Stimulus: rst_ni pulsed low during beat 2 of a TLP.
  - Response: m_axis_tvalid=0 asynchronously, grant_o=0; after release, the next replay request is granted from idle.
- Single requester:
  - Stimulus: 4-beat TLP (data 0x11..0x44), m_axis_tready=1.
  - Response: grant_o=3'b100; output beats appear one cycle after input; tlast on 0x44; idle on the next cycle.
- Simultaneous requests:
  - Stimulus: replay (2 beats), DLLP (1 beat) and TLP (3 beats) all valid at the same cycle.
  - Response: output order replay, DLLP, TLP; one bubble between packets; no interleaving of beats.
- No preemption:
  - Stimulus: replay becomes valid on beat 1 of a 5-beat TLP.
  - Response: the TLP completes intact; the replay is granted after the TLP tlast.
- Backpressure:
  - Stimulus: m_axis_tready toggles 1,0,0,1 during a DLLP.
  - Response: m_axis data held stable while stalled; s_dllp_axis_tready=0 while the register is full; no beat lost or duplicated.
- Starvation guard (ARB_STARVE_GUARD_EN, STARVE_LIMIT=2):
  - Stimulus: replay continuously valid, TLP valid.
  - Response: the TLP is granted after 2 replay packets, and the counter returns to 0.
  - Same stimulus with the macro undefined: the TLP is never granted while replay stays valid.

Source files
------------

// File: rtl/dllp_tx_arbiter_pkg.sv
// Shared definitions for the data link layer transmit arbiter.
// The optional TLP starvation guard is enabled with the ARB_STARVE_GUARD_EN macro.
package pcie_datalink_pkg;

    // Arbiter state: idle/arbitrating, or locked onto one source for a packet
    typedef enum logic [1:0] {
        ST_ARB_IDLE = 2'd0,
        ST_ARB_RPL  = 2'd1,
        ST_ARB_DLLP = 2'd2,
        ST_ARB_TLP  = 2'd3
    } arb_st_e;

    // Bit positions of each source inside grant_o
    localparam int ARB_RPL_IDX  = 0;
    localparam int ARB_DLLP_IDX = 1;
    localparam int ARB_TLP_IDX  = 2;

    // Width of the starvation counter
    localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/dllp_tx_arbiter_if.sv
// AXI-Stream bundle used for the arbiter's source ports and link-side output.
interface dllp_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/dllp_tx_arbiter_axis_out_reg.sv
// Single-entry registered AXI-Stream output stage. Upstream may push a beat
// whenever the register is empty or is being drained in the same cycle.
module axis_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic [KEEP_WIDTH-1:0] i_tkeep,
    input  logic                  i_tlast,
    input  logic [USER_WIDTH-1:0] i_tuser,
    input  logic                  i_m_tready,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic [KEEP_WIDTH-1:0] o_tkeep,
    output logic                  o_tlast,
    output logic [USER_WIDTH-1:0] o_tuser,
    output logic                  o_tvalid
);
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tlast;
    logic [USER_WIDTH-1:0] r_tuser;
    logic                  w_take;

    assign o_in_ready = !r_valid || i_m_tready;
    assign w_take     = i_load && o_in_ready;

    // Capture an accepted beat; otherwise empty the register once downstream takes it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_tdata <= '0;
            r_tkeep <= '0;
            r_tlast <= 1'b0;
            r_tuser <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_tdata <= i_tdata;
            r_tkeep <= i_tkeep;
            r_tlast <= i_tlast;
            r_tuser <= i_tuser;
        end else if (i_m_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_tvalid = r_valid;
    assign o_tdata  = r_tdata;
    assign o_tkeep  = r_tkeep;
    assign o_tlast  = r_tlast;
    assign o_tuser  = r_tuser;
endmodule

// File: rtl/dllp_tx_arbiter.sv
// Packet-locked arbiter sharing the link transmit stream between replay,
// DLLP and new-TLP sources (fixed priority replay > DLLP > TLP).
// Optional feature: define ARB_STARVE_GUARD_EN to let a waiting TLP win after
// STARVE_LIMIT consecutive replay/DLLP grants.
module dllp_tx_arbiter
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dllp_tx_arbiter_if.slave  s_rpl_axis,
    dllp_tx_arbiter_if.slave  s_dllp_axis,
    dllp_tx_arbiter_if.slave  s_tlp_axis,
    dllp_tx_arbiter_if.master m_axis,
    output logic [2:0]        grant_o,
    output logic              tlp_blocked_o
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    arb_st_e               r_state;
    arb_st_e               w_next_state;
    logic [DATA_WIDTH-1:0] w_sel_tdata;
    logic [KEEP_WIDTH-1:0] w_sel_tkeep;
    logic [USER_WIDTH-1:0] w_sel_tuser;
    logic                  w_sel_tvalid;
    logic                  w_sel_tlast;
    logic                  w_out_ready;
    logic                  w_load;
    logic                  w_starve_hit;

    // Route the locked source's beat toward the output register
    always_comb begin
        w_sel_tdata  = s_rpl_axis.tdata;
        w_sel_tkeep  = s_rpl_axis.tkeep;
        w_sel_tuser  = s_rpl_axis.tuser;
        w_sel_tlast  = s_rpl_axis.tlast;
        w_sel_tvalid = 1'b0;
        unique case (r_state)
            ST_ARB_RPL: begin
                w_sel_tvalid = s_rpl_axis.tvalid;
            end
            ST_ARB_DLLP: begin
                w_sel_tdata  = s_dllp_axis.tdata;
                w_sel_tkeep  = s_dllp_axis.tkeep;
                w_sel_tuser  = s_dllp_axis.tuser;
                w_sel_tlast  = s_dllp_axis.tlast;
                w_sel_tvalid = s_dllp_axis.tvalid;
            end
            ST_ARB_TLP: begin
                w_sel_tdata  = s_tlp_axis.tdata;
                w_sel_tkeep  = s_tlp_axis.tkeep;
                w_sel_tuser  = s_tlp_axis.tuser;
                w_sel_tlast  = s_tlp_axis.tlast;
                w_sel_tvalid = s_tlp_axis.tvalid;
            end
            default: ;
        endcase
    end

    assign w_load = w_sel_tvalid && w_out_ready;

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_out_reg (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_load     (w_load),
        .i_tdata    (w_sel_tdata),
        .i_tkeep    (w_sel_tkeep),
        .i_tlast    (w_sel_tlast),
        .i_tuser    (w_sel_tuser),
        .i_m_tready (m_axis.tready),
        .o_in_ready (w_out_ready),
        .o_tdata    (m_axis.tdata),
        .o_tkeep    (m_axis.tkeep),
        .o_tlast    (m_axis.tlast),
        .o_tuser    (m_axis.tuser),
        .o_tvalid   (m_axis.tvalid)
    );

`ifdef ARB_STARVE_GUARD_EN
    logic [ARB_CNT_W-1:0] r_starve_cnt;

    assign w_starve_hit = (r_starve_cnt >= ARB_CNT_W'(STARVE_LIMIT));

    // Count replay/DLLP wins that bypass a waiting TLP; any TLP grant or absent TLP clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_ARB_IDLE) begin
            if (!s_tlp_axis.tvalid || w_next_state == ST_ARB_TLP) begin
                r_starve_cnt <= '0;
            end else if ((w_next_state == ST_ARB_RPL || w_next_state == ST_ARB_DLLP) &&
                         r_starve_cnt != '1) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    assign w_starve_hit = 1'b0;
`endif

    // State register: restart from idle on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_ARB_IDLE;
        else         r_state <= w_next_state;
    end

    // Next state: arbitrate from idle, release the lock only on an accepted tlast
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_ARB_IDLE: begin
                if (w_starve_hit && s_tlp_axis.tvalid) w_next_state = ST_ARB_TLP;
                else if (s_rpl_axis.tvalid)            w_next_state = ST_ARB_RPL;
                else if (s_dllp_axis.tvalid)           w_next_state = ST_ARB_DLLP;
                else if (s_tlp_axis.tvalid)            w_next_state = ST_ARB_TLP;
            end
            default: begin
                if (w_load && w_sel_tlast) w_next_state = ST_ARB_IDLE;
            end
        endcase
    end

    // Outputs: grant decode, per-source ready and TLP-blocked flag
    always_comb begin
        grant_o = 3'b000;
        unique case (r_state)
            ST_ARB_RPL:  grant_o[ARB_RPL_IDX]  = 1'b1;
            ST_ARB_DLLP: grant_o[ARB_DLLP_IDX] = 1'b1;
            ST_ARB_TLP:  grant_o[ARB_TLP_IDX]  = 1'b1;
            default: ;
        endcase
        s_rpl_axis.tready  = grant_o[ARB_RPL_IDX]  && w_out_ready;
        s_dllp_axis.tready = grant_o[ARB_DLLP_IDX] && w_out_ready;
        s_tlp_axis.tready  = grant_o[ARB_TLP_IDX]  && w_out_ready;
        tlp_blocked_o      = s_tlp_axis.tvalid && !grant_o[ARB_TLP_IDX];
    end
endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// Scoreboard bench for dllp_tx_arbiter: directed scenarios plus randomized
// packet rounds, predicted at packet level from the priority rules.
module tb_dllp_tx_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } beat_t;

    localparam int LIMIT = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       m_tready = 1'b0;
    logic [2:0] grant;
    logic       tlp_blocked;

    beat_t      src_q [3][$];
    beat_t      pend  [3][$];
    beat_t      exp_q [$];
    beat_t      d_beat [3];
    logic       d_tvalid [3];
    logic       in_pkt [3];
    int         fired_cnt [3];
    logic [2:0] fire_n = '0;
    logic       rdy_pat [$];
    int         rdy_mode = 0;
    bit         gaps_en = 1'b0;

    logic       prev_fire = 1'b0, prev_last = 1'b0, stall_v = 1'b0;
    beat_t      prev_beat, stall_beat;

    int n_cmp = 0;
    int n_err = 0;

    dllp_tx_arbiter_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) rpl_if  ();
    dllp_tx_arbiter_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) dllp_if ();
    dllp_tx_arbiter_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) tlp_if  ();
    dllp_tx_arbiter_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) m_if    ();

    assign rpl_if.tdata   = d_beat[0].data;
    assign rpl_if.tkeep   = d_beat[0].keep;
    assign rpl_if.tuser   = d_beat[0].user;
    assign rpl_if.tlast   = d_beat[0].last;
    assign rpl_if.tvalid  = d_tvalid[0];
    assign dllp_if.tdata  = d_beat[1].data;
    assign dllp_if.tkeep  = d_beat[1].keep;
    assign dllp_if.tuser  = d_beat[1].user;
    assign dllp_if.tlast  = d_beat[1].last;
    assign dllp_if.tvalid = d_tvalid[1];
    assign tlp_if.tdata   = d_beat[2].data;
    assign tlp_if.tkeep   = d_beat[2].keep;
    assign tlp_if.tuser   = d_beat[2].user;
    assign tlp_if.tlast   = d_beat[2].last;
    assign tlp_if.tvalid  = d_tvalid[2];
    assign m_if.tready    = m_tready;

    wire [2:0] rdy = {tlp_if.tready, dllp_if.tready, rpl_if.tready};
    beat_t     m_out;
    assign m_out = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};

    dllp_tx_arbiter #(
        .DATA_WIDTH   (32),
        .KEEP_WIDTH   (4),
        .USER_WIDTH   (1),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .s_rpl_axis    (rpl_if),
        .s_dllp_axis   (dllp_if),
        .s_tlp_axis    (tlp_if),
        .m_axis        (m_if),
        .grant_o       (grant),
        .tlp_blocked_o (tlp_blocked)
    );

    // Free-running clock
    initial forever #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_pkt(input int k, input int n, input logic [31:0] first, input logic [31:0] step);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = first + 32'(i) * step;
            b.keep = 4'($urandom);
            b.user = 1'($urandom);
            b.last = (i == n - 1);
            src_q[k].push_back(b);
            pend[k].push_back(b);
        end
    endtask

    // Packet-level reference: all sources with pending packets compete at
    // each arbitration; highest priority wins unless a TLP is being starved.
    task automatic predict();
        int    cnt = 0;
        int    w;
        bit    tlp_avail;
        beat_t b;
        while (pend[0].size() + pend[1].size() + pend[2].size() > 0) begin
            tlp_avail = pend[2].size() > 0;
            if (GUARD && tlp_avail && cnt >= LIMIT) w = 2;
            else if (pend[0].size() > 0)            w = 0;
            else if (pend[1].size() > 0)            w = 1;
            else                                    w = 2;
            if (w == 2 || !tlp_avail) cnt = 0;
            else if (cnt < 15)        cnt++;
            do begin
                b = pend[w].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
        end
    endtask

    task automatic wait_grant(input logic [2:0] exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant != 3'b000) break;
        end
        chk("first_grant", 64'(grant), 64'(exp));
    endtask

    task automatic wait_drain(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                   src_q[2].size() == 0 && !m_if.tvalid;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain: %0d beats still expected after %0d cycles, required 0", exp_q.size(), limit);
            exp_q.delete();
            for (int k = 0; k < 3; k++) pend[k].delete();
            #2 rst_ni = 1'b0;
            @(negedge clk);
            #2 rst_ni = 1'b1;
        end
    endtask

    // Source drivers: advance on a handshake seen before the edge, present next beat
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rst_ni) begin
                src_q[k].delete();
                d_tvalid[k] = 1'b0;
                in_pkt[k]   = 1'b0;
            end else begin
                if (fire_n[k] && src_q[k].size() > 0) begin
                    in_pkt[k] = !src_q[k][0].last;
                    void'(src_q[k].pop_front());
                    fired_cnt[k]++;
                    d_tvalid[k] = 1'b0;
                end
                if (!d_tvalid[k] && src_q[k].size() > 0) begin
                    if (!(gaps_en && in_pkt[k] && $urandom_range(2) == 0)) begin
                        d_tvalid[k] = 1'b1;
                        d_beat[k]   = src_q[k][0];
                    end
                end
            end
        end
    end

    // Link-side ready: optional pattern applied while data is held, else by mode
    always @(posedge clk) begin
        #1;
        if (rdy_pat.size() > 0) begin
            if (m_if.tvalid) m_tready = rdy_pat.pop_front();
            else             m_tready = 1'b1;
        end else begin
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(2) != 0);
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: protocol rules each cycle and scoreboard compare on output handshakes
    always @(negedge clk) begin
        if (!rst_ni) begin
            fire_n    = '0;
            prev_fire = 1'b0;
            prev_last = 1'b0;
            stall_v   = 1'b0;
        end else begin
            chk("ready_rule", 64'(rdy), 64'(grant & {3{!m_if.tvalid || m_tready}}));
            chk("tlp_blocked", 64'(tlp_blocked), 64'(d_tvalid[2] && !grant[2]));
            chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
            if (prev_fire) chk("latency", 64'({m_if.tvalid, m_out}), 64'({1'b1, prev_beat}));
            if (prev_last) chk("idle_after_last", 64'(grant), 64'd0);
            if (stall_v)   chk("stall_hold", 64'({m_if.tvalid, m_out}), 64'({1'b1, stall_beat}));
            if (m_if.tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_beat: got unexpected beat %0h, expected none", m_out);
                end else begin
                    chk("out_beat", 64'(m_out), 64'(exp_q.pop_front()));
                end
            end
            stall_v    = m_if.tvalid && !m_tready;
            stall_beat = m_out;
            prev_fire  = 1'b0;
            prev_last  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                fire_n[k] = d_tvalid[k] && rdy[k];
                if (fire_n[k]) begin
                    prev_fire = 1'b1;
                    prev_beat = d_beat[k];
                    prev_last = d_beat[k].last;
                end
            end
        end
    end

    // Scenario sequence
    initial begin
        int c0;
        for (int k = 0; k < 3; k++) begin
            d_tvalid[k]  = 1'b0;
            in_pkt[k]    = 1'b0;
            fired_cnt[k] = 0;
            d_beat[k]    = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_out", 64'({m_if.tvalid, m_out}), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_blocked", 64'(tlp_blocked), 64'd0);
        #2 rst_ni = 1'b1;
        @(negedge clk);

        // single requester: 4-beat TLP 0x11..0x44
        add_pkt(2, 4, 32'h11, 32'h11);
        predict();
        wait_grant(3'b100);
        wait_drain(100);

        // simultaneous requests
        add_pkt(0, 2, 32'hA000_0001, 1);
        add_pkt(1, 1, 32'hB000_0001, 1);
        add_pkt(2, 3, 32'hC000_0001, 1);
        predict();
        wait_drain(100);

        // no preemption: replay arrives once the TLP is under way
        add_pkt(2, 5, 32'hD000_0001, 1);
        predict();
        wait_grant(3'b100);
        add_pkt(0, 2, 32'hE000_0001, 1);
        predict();
        wait_drain(100);

        // backpressure during a DLLP
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1);
        add_pkt(1, 3, 32'hF000_0001, 1);
        predict();
        wait_drain(100);

        // starvation: replay keeps requesting while a TLP waits
        for (int p = 0; p < 3; p++) add_pkt(0, 2, 32'h5000_0000 + 32'(p * 16), 1);
        add_pkt(2, 2, 32'h6000_0000, 1);
        predict();
        wait_drain(200);

        // reset during beat 2 of a TLP
        c0 = fired_cnt[2];
        add_pkt(2, 4, 32'h7000_0001, 1);
        predict();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fired_cnt[2] > c0) break;
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("async_rst_grant", 64'(grant), 64'd0);
        chk("async_rst_tdata", 64'(m_if.tdata), 64'd0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) pend[k].delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        add_pkt(0, 2, 32'h8000_0001, 1);
        predict();
        wait_grant(3'b001);
        wait_drain(100);

        // randomized rounds with mid-packet gaps and random link backpressure
        gaps_en  = 1'b1;
        rdy_mode = 1;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                int np = $urandom_range(3);
                for (int p = 0; p < np; p++) add_pkt(k, $urandom_range(1, 4), $urandom, 1);
            end
            predict();
            wait_drain(2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
